pwm_multi_driver: RTL

Multi-channel, parametrised PWM generator that replaces the single-channel PWM driver. All channels share one prescaler and one period counter. Each channel has its own duty register, enable and compare output. Duty, period and alignment mode are double-buffered and take effect only at a period boundary, so outputs never glitch. It sits on the peripheral side of the processor and is driven by the same register-write strobes as the other output peripherals.

---
 rtl/pwm_multi_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_driver.sv
// pwm_multi_driver: multi-channel PWM generator with a shared prescaler and
// period counter, edge- or center-aligned counting, and double-buffered
// duty/period/mode registers that only change at a period boundary.
module pwm_multi_driver #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 100,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_duty,
  input  logic              period_we,
  input  logic [WIDTH-1:0]  period_value,
  input  logic              center_mode,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TOP_RST  = '1;
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  dir_e              dir_q, dir_d;
  logic [WIDTH-1:0]  top_pend_q, top_pend_d;
  logic [WIDTH-1:0]  top_act_q, top_act_d;
  logic              mode_pend_q, mode_pend_d;
  logic              mode_act_q, mode_act_d;
  logic [WIDTH-1:0]  duty_pend_q [NUM_CH];
  logic [WIDTH-1:0]  duty_pend_d [NUM_CH];
  logic [WIDTH-1:0]  duty_act_q  [NUM_CH];
  logic [WIDTH-1:0]  duty_act_d  [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_tick_q, period_tick_d;
  logic              tick;
  logic              boundary;

  // Prescaler: wraps after PRESCALE cycles; the wrap cycle is the tick.
  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + PS_W'(1);
  end

  // Counter and direction: advance on tick, detect the boundary (next count is 0).
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (tick) begin
      if (top_act_q == '0) begin
        boundary = 1'b1;
      end else if (!mode_act_q) begin
        if (cnt_q >= top_act_q) begin
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= top_act_q) begin
          dir_d = DIR_DOWN;
          cnt_d = top_act_q - WIDTH'(1);
          if (top_act_q == WIDTH'(1)) begin
            boundary = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q <= WIDTH'(1)) begin
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      if (boundary) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end
    end
  end

  // Pending/active buffers: writes land in pending, and a boundary copies the
  // pending value (including a write in that same cycle) into the active set.
  always_comb begin
    top_pend_d  = period_we ? period_value : top_pend_q;
    mode_pend_d = center_mode;
    top_act_d   = boundary ? top_pend_d : top_act_q;
    mode_act_d  = boundary ? mode_pend_d : mode_act_q;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_pend_d[i] = (cfg_we && (cfg_ch == CH_W'(i))) ? cfg_duty : duty_pend_q[i];
      duty_act_d[i]  = boundary ? duty_pend_d[i] : duty_act_q[i];
    end
  end

  // Compare against the next counter/duty so outputs line up with period_tick.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = ch_enable[i] & (cnt_d < duty_act_d[i]);
    end
    period_tick_d = boundary;
  end

  // Timebase registers: prescaler, counter and direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Configuration registers: pending and active copies of top, mode and duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_pend_q  <= TOP_RST;
      top_act_q   <= TOP_RST;
      mode_pend_q <= 1'b0;
      mode_act_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_pend_q[i] <= DUTY_RST;
        duty_act_q[i]  <= DUTY_RST;
      end
    end else begin
      top_pend_q  <= top_pend_d;
      top_act_q   <= top_act_d;
      mode_pend_q <= mode_pend_d;
      mode_act_q  <= mode_act_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_pend_q[i] <= duty_pend_d[i];
        duty_act_q[i]  <= duty_act_d[i];
      end
    end
  end

  // Output registers: PWM compare results and the boundary pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;

endmodule
